// File: rtl/intr_controller_if.sv
// Bus bundle between a CPU-side agent and the interrupt controller.
// The CPU side drives requests, mask writes and ack/eoi; the controller drives int_req/int_id/in_service/pending.
interface intr_if;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned ID_W      = 3;

    logic [NUM_LINES-1:0] irq_in;
    logic                 mask_we;
    logic [NUM_LINES-1:0] mask_data;
    logic                 ack;
    logic                 eoi;
    logic                 int_req;
    logic [ID_W-1:0]      int_id;
    logic                 in_service;
    logic [NUM_LINES-1:0] pending;

    modport master (
        output irq_in, mask_we, mask_data, ack, eoi,
        input  int_req, int_id, in_service, pending
    );

    modport slave (
        input  irq_in, mask_we, mask_data, ack, eoi,
        output int_req, int_id, in_service, pending
    );
endinterface

// File: rtl/intr_controller.sv
// 8-line edge-triggered interrupt controller with fixed priority (line 7 highest) and ack/eoi handshake.
// Optional macro INTR_SYNC_EN inserts a two-flop synchronizer on irq_in ahead of edge detection.
module intr_controller (
    input  logic clk,
    input  logic reset,
    intr_if.slave bus
);
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned ID_W      = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] irq_s;
    logic [NUM_LINES-1:0] prev_q;
    logic [NUM_LINES-1:0] pending_q, pending_d;
    logic [NUM_LINES-1:0] mask_q, mask_d;
    logic [NUM_LINES-1:0] rise_c, clr_c, avail_c;
    logic                 int_req_q, int_req_d;
    logic                 in_service_q, in_service_d;
    logic [ID_W-1:0]      int_id_q, int_id_d;
    logic [ID_W-1:0]      top_id_c;

`ifdef INTR_SYNC_EN
    logic [NUM_LINES-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer per request line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = bus.irq_in;
`endif

    assign rise_c  = irq_s & ~prev_q;
    assign avail_c = pending_q & ~mask_q;
    assign mask_d  = bus.mask_we ? bus.mask_data : mask_q;

    // Highest set index wins; ascending scan lets later (higher) bits overwrite
    always_comb begin
        top_id_c = '0;
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            if (avail_c[i]) top_id_c = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= irq_s;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
        end
    end

    // Next-state logic; a new edge on the line being acked wins over its clear
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_id_d     = int_id_q;
        in_service_d = in_service_q;
        clr_c        = '0;

        case (state_q)
            IDLE: begin
                if (avail_c != '0) begin
                    int_id_d  = top_id_c;
                    int_req_d = 1'b1;
                    state_d   = REQUEST;
                end
            end
            REQUEST: begin
                if (bus.ack) begin
                    clr_c[int_id_q] = 1'b1;
                    int_req_d       = 1'b0;
                    in_service_d    = 1'b1;
                    state_d         = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                int_req_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase

        pending_d = (pending_q & ~clr_c) | rise_c;
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_id     = int_id_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: vector table for the unsynchronized build plus
// hand sequences for latency, async reset and reset-release edge detection.
module tb_intr_controller;
    logic clk;
    logic reset;
    intr_if bus();

    intr_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       mwe;
        logic [7:0] mdata;
        logic       ack;
        logic       eoi;
        logic       e_req;
        logic [2:0] e_id;
        logic       e_ins;
        logic [7:0] e_pend;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic r, input logic [7:0] irq, input logic mwe,
                                input logic [7:0] md, input logic a, input logic e,
                                input logic rq, input logic [2:0] id, input logic ins,
                                input logic [7:0] pd);
        vec_t v;
        v.rst = r; v.irq = irq; v.mwe = mwe; v.mdata = md; v.ack = a; v.eoi = e;
        v.e_req = rq; v.e_id = id; v.e_ins = ins; v.e_pend = pd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] irq, input logic mwe,
                         input logic [7:0] md, input logic a, input logic e);
        reset         = r;
        bus.irq_in    = irq;
        bus.mask_we   = mwe;
        bus.mask_data = md;
        bus.ack       = a;
        bus.eoi       = e;
    endtask

    initial begin
        int lat;
        int exp_lat;

        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

`ifndef INTR_SYNC_EN
        //        rst irq    mwe mdata  ack eoi  req id ins pend
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00));
        // three lines at once, served in priority order
        vecs.push_back(mk(0, 8'h91, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h91));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd7, 0, 8'h91));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd7, 0, 8'h91));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 3'd7, 1, 8'h11));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd7, 1, 8'h11));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 3'd7, 0, 8'h11));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd4, 0, 8'h11));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 3'd4, 1, 8'h01));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 3'd4, 0, 8'h01));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd0, 0, 8'h01));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 3'd0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 3'd0, 0, 8'h00));
        // masked line still latches pending but is not presented
        vecs.push_back(mk(0, 8'h00, 1, 8'h80, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h80, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h80));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h80));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h80));
        vecs.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0, 0, 3'd0, 0, 8'h80));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd7, 0, 8'h80));
        vecs.push_back(mk(0, 8'h00, 1, 8'hFF, 0, 0, 1, 3'd7, 0, 8'h80));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 3'd7, 1, 8'h00));
        vecs.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0, 0, 3'd7, 1, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 3'd7, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd7, 0, 8'h00));
        // edge on line 5 coincides with its ack clear
        vecs.push_back(mk(0, 8'h20, 0, 8'h00, 0, 0, 0, 3'd7, 0, 8'h20));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd5, 0, 8'h20));
        vecs.push_back(mk(0, 8'h20, 0, 8'h00, 1, 0, 0, 3'd5, 1, 8'h20));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 3'd5, 0, 8'h20));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd5, 0, 8'h20));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 3'd5, 1, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 3'd5, 0, 8'h00));
        // line 5 held high for 10 cycles: one service only
        vecs.push_back(mk(0, 8'h20, 0, 8'h00, 0, 0, 0, 3'd5, 0, 8'h20));
        vecs.push_back(mk(0, 8'h20, 0, 8'h00, 0, 0, 1, 3'd5, 0, 8'h20));
        vecs.push_back(mk(0, 8'h20, 0, 8'h00, 1, 0, 0, 3'd5, 1, 8'h00));
        vecs.push_back(mk(0, 8'h20, 0, 8'h00, 0, 1, 0, 3'd5, 0, 8'h00));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 8'h20, 0, 8'h00, 0, 0, 0, 3'd5, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd5, 0, 8'h00));
        // reset while servicing with pending = 0A, line 0 held through release
        vecs.push_back(mk(0, 8'h0A, 0, 8'h00, 0, 0, 0, 3'd5, 0, 8'h0A));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 3'd3, 0, 8'h0A));
        vecs.push_back(mk(0, 8'h08, 0, 8'h00, 1, 0, 0, 3'd3, 1, 8'h0A));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd3, 1, 8'h0A));
        vecs.push_back(mk(1, 8'h01, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h01));
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 0, 1, 3'd0, 0, 8'h01));
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 3'd0, 0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].irq, vecs[i].mwe, vecs[i].mdata, vecs[i].ack, vecs[i].eoi);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.int_req", i),    8'(bus.int_req),    8'(vecs[i].e_req));
            chk($sformatf("v%0d.int_id", i),     8'(bus.int_id),     8'(vecs[i].e_id));
            chk($sformatf("v%0d.in_service", i), 8'(bus.in_service), 8'(vecs[i].e_ins));
            chk($sformatf("v%0d.pending", i),    bus.pending,        vecs[i].e_pend);
        end
`endif

        // Clean restart before the build-independent sequences
        @(negedge clk);
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Latency from a 3-cycle pulse on line 3 to int_req
`ifdef INTR_SYNC_EN
        exp_lat = 4;
`else
        exp_lat = 2;
`endif
        lat = 0;
        bus.irq_in = 8'h08;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.int_req) begin
                lat = c;
                break;
            end
            if (c == 3) bus.irq_in = 8'h00;
        end
        bus.irq_in = 8'h00;
        chk("latency", 8'(lat), 8'(exp_lat));
        chk("lat.int_id", 8'(bus.int_id), 8'd3);

        // Accept, then raise line 6 while in service
        @(negedge clk);
        bus.ack    = 1'b1;
        bus.irq_in = 8'h40;
        @(posedge clk);
        #1;
        chk("seq.ack.in_service", 8'(bus.in_service), 8'd1);
        chk("seq.ack.int_req",    8'(bus.int_req),    8'd0);
        @(negedge clk);
        bus.ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("seq.pend40", bus.pending, 8'h40);
        chk("seq.still_service", 8'(bus.in_service), 8'd1);

        // Reset asserted away from any clock edge must clear immediately
        #2;
        reset = 1'b1;
        #1;
        chk("async.in_service", 8'(bus.in_service), 8'd0);
        chk("async.int_id",     8'(bus.int_id),     8'd0);
        chk("async.pending",    bus.pending,        8'h00);

        // Line 6 held across release counts as a fresh edge
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.int_req) begin
                lat = c;
                break;
            end
        end
        chk("release.latency", 8'(lat), 8'(exp_lat));
        chk("release.int_id",  8'(bus.int_id), 8'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other ports SHALL be as listed below.
REQ-002 clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 irq_in  input  8  raw interrupt request lines from peripherals; a rising edge requests service.
REQ-005 mask_we  input  1  when high, load mask_data into the mask register.
REQ-006 mask_data  input  8  new mask value; bit=1 disables the line.
REQ-007 ack  input  1  CPU accepts the presented interrupt.
REQ-008 eoi  input  1  CPU signals end of the service routine.
REQ-009 int_req  output  1  registered interrupt request to the CPU.
REQ-010 int_id  output  3  index of the presented or in-service line.
REQ-011 in_service  output  1  high while a routine is being serviced.
REQ-012 pending  output  8  latched pending bits, unmasked view.

Function
REQ-013 The block SHALL keep a prev register of irq_in, one bit per line; edge(i) SHALL be true when the sampled irq(i)=1 and prev(i)=0.
REQ-014 On the clock edge where edge(i) is true, pending(i) SHALL be set; a held-high line SHALL NOT re-set the bit until it falls and rises again.
REQ-015 The mask SHALL hide pending bits from arbitration only; masked edges SHALL still set pending.
REQ-016 The state machine SHALL have states IDLE, REQUEST and SERVICE.
REQ-017 IDLE: if (pending & ~mask) != 0 the block SHALL latch int_id as the highest set index (bit 7 highest priority) and go to REQUEST; int_req SHALL be high from the next cycle.
REQ-018 REQUEST: int_req SHALL stay high and int_id SHALL stay stable until ack; a higher-priority arrival SHALL NOT preempt the presented id.
REQ-019 REQUEST with ack=1: the block SHALL clear pending(int_id), drop int_req, set in_service and go to SERVICE on the same edge.
REQ-020 SERVICE with eoi=1: the block SHALL clear in_service and return to IDLE; arbitration SHALL resume from the following cycle.
REQ-021 ack outside REQUEST and eoi outside SERVICE SHALL be ignored.
REQ-022 If an edge on line int_id coincides with its clear on ack, set SHALL win and pending(int_id) SHALL remain 1.
REQ-023 A mask write during REQUEST or SERVICE SHALL NOT withdraw the current request or service; it SHALL affect the next arbitration only.
REQ-024 The minimum latency without synchronizer SHALL be: edge sampled at edge N, pending at N, int_req high after edge N+1.

Reset
REQ-025 While reset is high, the state SHALL be IDLE, and pending, mask, prev, int_req, int_id and in_service SHALL all be 0.
REQ-026 Reset mid-operation SHALL abort any request or service immediately, with no pending bit retained.
REQ-027 A line already high at reset release SHALL count as a rising edge on the first clock edge, because prev resets to 0.

Configuration
REQ-028 Macro INTR_SYNC_EN defined: each irq_in line SHALL pass through a two-flop synchronizer, reset to 0, before edge detection, adding 2 cycles to every latency above.
REQ-029 Macro INTR_SYNC_EN undefined: irq_in SHALL feed edge detection directly, with the latency of REQ-024.

Verification (INTR_SYNC_EN undefined unless stated)
REQ-030 irq_in=8'b10010001 for one cycle, then 0 -> pending=8'h91; int_req=1 with int_id=7; after ack, pending=8'h11; after eoi, int_id=4, then 0 in turn.
REQ-031 mask written to 8'h80, then irq_in pulse 8'h80 -> pending(7)=1 and int_req stays 0; write mask=8'h00 -> int_req=1 with int_id=7.
REQ-032 irq(5) rises on the same edge ack clears id 5 -> pending(5)=1 afterwards, and id 5 is presented again after eoi.
REQ-033 irq_in held at 8'h20 for 10 cycles -> exactly one service of id 5; no re-request after eoi.
REQ-034 reset pulsed during SERVICE with pending=8'h0A -> all outputs 0 and state IDLE; with irq_in=8'h01 held through reset release -> int_req=1 with int_id=0.
REQ-035 INTR_SYNC_EN defined, single pulse on irq(3) held for 3 cycles -> int_req rises exactly 2 cycles later than in the unsynchronized build.
